// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control sequencer.
package pipe_ctrl_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_JUMP_WAIT = 2'd1,
        ST_REDIRECT  = 2'd2
    } state_e;

    // Enable/flush bundle for PC, IF/ID and ID/EX
    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
    } ctrl_t;

    // Reset bundle: nothing advances, both pipeline registers hold bubbles
    localparam ctrl_t CTRL_NOP = '{pc_en: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0,
                                   if_id_flush: 1'b1, id_ex_en: 1'b0, id_ex_flush: 1'b1};
    // Normal flow
    localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, pc_redirect: 1'b0, if_id_en: 1'b1,
                                   if_id_flush: 1'b0, id_ex_en: 1'b1, id_ex_flush: 1'b0};
    // Memory freeze: everything holds
    localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0,
                                      if_id_flush: 1'b0, id_ex_en: 1'b0, id_ex_flush: 1'b0};
    // Load-use bubble into ID/EX, PC and IF/ID hold
    localparam ctrl_t CTRL_LOAD = '{pc_en: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0,
                                    if_id_flush: 1'b0, id_ex_en: 1'b1, id_ex_flush: 1'b1};
    // Jump advancing / waiting: kill wrong-path fetch, PC holds
    localparam ctrl_t CTRL_JUMP = '{pc_en: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b1,
                                    if_id_flush: 1'b1, id_ex_en: 1'b1, id_ex_flush: 1'b0};
    // Load EX target into PC
    localparam ctrl_t CTRL_REDIR = '{pc_en: 1'b1, pc_redirect: 1'b1, if_id_en: 1'b1,
                                     if_id_flush: 1'b1, id_ex_en: 1'b1, id_ex_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-unit / pipeline-control bundle between the sequencer and its surroundings.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             load_stall;
    logic             jump_stall;
    logic             mem_busy;
    logic             redirect_valid;
    logic             pc_en;
    logic             pc_redirect;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             hazard_err;
    logic [CNT_W-1:0] perf_load_cnt;
    logic [CNT_W-1:0] perf_jump_cnt;
    logic [CNT_W-1:0] perf_frz_cnt;

    // Side that produces hazards and consumes controls
    modport master (
        output load_stall, jump_stall, mem_busy, redirect_valid,
        input  pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  hazard_err, perf_load_cnt, perf_jump_cnt, perf_frz_cnt
    );

    // The sequencer itself
    modport slave (
        input  load_stall, jump_stall, mem_busy, redirect_valid,
        output pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output hazard_err, perf_load_cnt, perf_jump_cnt, perf_frz_cnt
    );
endinterface

// File: rtl/pipe_ctrl_perf_counter.sv
// Wrapping event counter, one increment per cycle with inc high.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: stalls, jump wait with watchdog, redirect.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
// rst is asynchronous and active-low. Controls are combinational so a
// stall takes effect in the same cycle the hazard is flagged.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);
    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                err_q, err_d;
    ctrl_t               ctrl;

    // Next state and control decode; mem_busy > load_stall > jump_stall
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        ctrl       = CTRL_RUN;
        if (!rst) begin
            ctrl = CTRL_NOP;
        end else if (bus.mem_busy) begin
            ctrl = CTRL_FREEZE;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.load_stall) begin
                        ctrl = CTRL_LOAD;
                    end else if (bus.jump_stall) begin
                        ctrl       = CTRL_JUMP;
                        wait_cnt_d = '0;
                        state_d    = ST_JUMP_WAIT;
                    end
                end
                ST_JUMP_WAIT: begin
                    ctrl       = CTRL_JUMP;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (bus.redirect_valid) begin
                        state_d = ST_REDIRECT;
                    end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    ctrl    = CTRL_REDIR;
                    state_d = ST_RUN;
                end
                default: begin
                    ctrl    = CTRL_NOP;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, wait counter and sticky watchdog flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.pc_en       = ctrl.pc_en;
    assign bus.pc_redirect = ctrl.pc_redirect;
    assign bus.if_id_en    = ctrl.if_id_en;
    assign bus.if_id_flush = ctrl.if_id_flush;
    assign bus.id_ex_en    = ctrl.id_ex_en;
    assign bus.id_ex_flush = ctrl.id_ex_flush;
    assign bus.hazard_err  = err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic inc_load, inc_jump, inc_frz;

    // Event strobes matching the decode priority above
    assign inc_frz  = bus.mem_busy;
    assign inc_load = !bus.mem_busy && (state_q == ST_RUN) && bus.load_stall;
    assign inc_jump = !bus.mem_busy && (state_q == ST_JUMP_WAIT);

    perf_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk (clk), .rst (rst), .inc (inc_load), .cnt (bus.perf_load_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_jump_cnt (
        .clk (clk), .rst (rst), .inc (inc_jump), .cnt (bus.perf_jump_cnt)
    );
    perf_counter #(.CNT_W(CNT_W)) u_frz_cnt (
        .clk (clk), .rst (rst), .inc (inc_frz), .cnt (bus.perf_frz_cnt)
    );
`else
    assign bus.perf_load_cnt = CNT_W'(0);
    assign bus.perf_jump_cnt = CNT_W'(0);
    assign bus.perf_frz_cnt  = CNT_W'(0);
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl.
module tb_pipe_ctrl;

    // Expected control patterns: {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush}
    localparam logic [5:0] E_NOP = 6'b000101;
    localparam logic [5:0] E_RUN = 6'b101010;
    localparam logic [5:0] E_FRZ = 6'b000000;
    localparam logic [5:0] E_LD  = 6'b000011;
    localparam logic [5:0] E_JMP = 6'b001110;
    localparam logic [5:0] E_RDR = 6'b111110;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic       ld;
        logic       jp;
        logic       busy;
        logic       rdr;
        logic [5:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(32)) bus ();

    pipe_ctrl #(.MAX_WAIT(8), .WAIT_W(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [5:0] outs();
        return {bus.pc_en, bus.pc_redirect, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply inputs mid-cycle, then settle before sampling
    task automatic drive(input logic ld, input logic jp, input logic busy, input logic rdr);
        @(negedge clk);
        bus.load_stall     = ld;
        bus.jump_stall     = jp;
        bus.mem_busy       = busy;
        bus.redirect_valid = rdr;
        #1;
    endtask

    task automatic add(input logic ld, input logic jp, input logic busy, input logic rdr, input logic [5:0] exp);
        vec_t v;
        v.ld = ld; v.jp = jp; v.busy = busy; v.rdr = rdr; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        bus.load_stall = 1'b0; bus.jump_stall = 1'b0;
        bus.mem_busy = 1'b0; bus.redirect_valid = 1'b0;

        // Sequence from RUN: load bubble, jump+redirect, priority, freeze in wait
        add(0,0,0,0, E_RUN);  // 0
        add(1,0,0,0, E_LD);   // 1 load bubble
        add(0,0,0,0, E_RUN);  // 2
        add(0,1,0,0, E_JMP);  // 3 -> JUMP_WAIT
        add(0,0,0,0, E_JMP);  // 4 wait
        add(0,0,0,1, E_JMP);  // 5 wait, redirect arrives
        add(0,0,0,0, E_RDR);  // 6 REDIRECT
        add(0,0,0,0, E_RUN);  // 7
        add(1,1,0,0, E_LD);   // 8 load beats jump
        add(0,1,0,0, E_JMP);  // 9 -> JUMP_WAIT
        add(0,0,1,1, E_FRZ);  // 10 frozen, redirect ignored
        add(0,0,1,1, E_FRZ);  // 11
        add(0,0,1,1, E_FRZ);  // 12
        add(0,0,0,1, E_JMP);  // 13 redirect taken
        add(0,0,0,0, E_RDR);  // 14
        add(0,0,0,1, E_RUN);  // 15 redirect ignored in RUN
        add(0,0,1,0, E_FRZ);  // 16 freeze in RUN
        add(0,0,0,0, E_RUN);  // 17
        add(0,1,0,0, E_JMP);  // 18 -> JUMP_WAIT
        add(1,0,0,0, E_JMP);  // 19 load ignored in wait
        add(0,0,0,1, E_JMP);  // 20 redirect
        add(0,0,0,0, E_RDR);  // 21
        add(0,0,0,0, E_RUN);  // 22

        // Reset held: inputs pulsed, controls stay at bubble values
        drive(1,1,0,1); check("rst_ctrl_a", 32'(outs()), 32'(E_NOP));
        drive(0,1,1,1); check("rst_ctrl_b", 32'(outs()), 32'(E_NOP));
        check("rst_err", 32'(bus.hazard_err), 32'd0);
        check("rst_perf_load", bus.perf_load_cnt, 32'd0);
        drive(0,0,0,0); check("rst_ctrl_c", 32'(outs()), 32'(E_NOP));
        rst = 1'b1; #1;
        check("release_run", 32'(outs()), 32'(E_RUN));

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].jp, vecs[i].busy, vecs[i].rdr);
            check($sformatf("vec%0d_ctrl", i), 32'(outs()), 32'(vecs[i].exp));
            check($sformatf("vec%0d_err", i), 32'(bus.hazard_err), 32'd0);
            if (i == 2) check("perf_load_after_bubble", bus.perf_load_cnt, PERF ? 32'd1 : 32'd0);
            if (i == 7) check("perf_jump_after_redirect", bus.perf_jump_cnt, PERF ? 32'd2 : 32'd0);
        end
        check("perf_load_tbl", bus.perf_load_cnt, PERF ? 32'd2 : 32'd0);
        check("perf_jump_tbl", bus.perf_jump_cnt, PERF ? 32'd5 : 32'd0);
        check("perf_frz_tbl",  bus.perf_frz_cnt,  PERF ? 32'd4 : 32'd0);

        // Watchdog: jump with no redirect for MAX_WAIT cycles
        drive(0,1,0,0); check("wd_enter", 32'(outs()), 32'(E_JMP));
        for (int k = 0; k < 8; k++) begin
            drive(0,0,0,0);
            check($sformatf("wd_wait%0d", k), 32'(outs()), 32'(E_JMP));
            check($sformatf("wd_err_low%0d", k), 32'(bus.hazard_err), 32'd0);
        end
        drive(0,0,0,1); check("wd_back_run", 32'(outs()), 32'(E_RUN));
        check("wd_err_set", 32'(bus.hazard_err), 32'd1);
        drive(1,0,0,0); check("wd_err_sticky_a", 32'(bus.hazard_err), 32'd1);
        drive(0,0,1,0); check("wd_err_sticky_b", 32'(bus.hazard_err), 32'd1);
        drive(0,0,0,0); check("perf_jump_wd", bus.perf_jump_cnt, PERF ? 32'd13 : 32'd0);

        // Async reset in the middle of a jump wait
        drive(0,1,0,0); check("ar_enter", 32'(outs()), 32'(E_JMP));
        drive(0,0,0,1); check("ar_wait", 32'(outs()), 32'(E_JMP));
        rst = 1'b0; #1;
        check("ar_ctrl", 32'(outs()), 32'(E_NOP));
        check("ar_err_clr", 32'(bus.hazard_err), 32'd0);
        check("ar_perf_jump", bus.perf_jump_cnt, 32'd0);
        drive(0,0,0,1); check("ar_held", 32'(outs()), 32'(E_NOP));
        drive(0,0,0,0);
        rst = 1'b1; #1;
        check("ar_release_run", 32'(outs()), 32'(E_RUN));
        drive(0,0,0,0); check("ar_no_redirect", 32'(outs()), 32'(E_RUN));
        check("ar_err_low", 32'(bus.hazard_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
